// File: rtl/arb4x2_pkg.sv
// Shared constants, state encoding and the one-hot/index helper for the
// four-requester round-robin arbiter.
package arb4x2_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/arb4x2_pick.sv
// Circular first-set scan starting at ptr over req & mask (mask bit 1 = eligible).
// Purely combinational.
module arb4x2_pick
   import arb4x2_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N_REQ-1:0] eff;
   logic [IDX_W-1:0] cand;

   assign eff = req & mask;

   // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (eff[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb4x2_rr.sv
// Round-robin arbiter: registered one-hot grant with encoded index, direct
// hand-off on release and forced rotation after HOLD_MAX cycles under contention.
module arb4x2_rr
   import arb4x2_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             preempt
);

   localparam int               CNT_W   = $clog2(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cur_q, cur_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             preempt_d;
   logic [N_REQ-1:0] gnt_d;

   logic [N_REQ-1:0] mask;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   // IDLE needs the plain scan, OWN only ever needs competitors of cur.
   assign mask = (state_q == OWN) ? ~idx_to_onehot(cur_q) : {N_REQ{1'b1}};

   arb4x2_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (mask),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWN;
               cur_d   = pick_idx;
               ptr_d   = pick_idx + IDX_W'(1);
               cnt_d   = '0;
            end
         end
         OWN: begin
            if (!req[cur_q]) begin
               // Release wins over a coincident timeout, so no preempt here.
               if (pick_found) begin
                  cur_d = pick_idx;
                  ptr_d = pick_idx + IDX_W'(1);
               end else begin
                  state_d = IDLE;
               end
               cnt_d = '0;
            end else if (pick_found && cnt_q == CNT_MAX) begin
               cur_d     = pick_idx;
               ptr_d     = pick_idx + IDX_W'(1);
               cnt_d     = '0;
               preempt_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_d = (state_d == OWN) ? idx_to_onehot(cur_d) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         preempt <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt     <= gnt_d;
         gnt_idx <= onehot_to_idx(gnt_d);
         gnt_vld <= |gnt_d;
         preempt <= preempt_d;
      end
   end

endmodule

// File: tb/tb_arb4x2_rr.sv
// Directed bench for arb4x2_rr (HOLD_MAX=4); expected grants queued per step
// and compared one cycle later with immediate assertions.
module tb_arb4x2_rr;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       preempt;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] idx;
      logic       vld;
      logic       pre;
   } exp_t;

   exp_t sb[$];
   int   n_assert;
   int   n_fail;

   arb4x2_rr #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] g, input logic p);
      exp_t e;
      e.g   = g;
      e.vld = (g != 4'b0000);
      e.pre = p;
      case (g)
         4'b0010: e.idx = 2'd1;
         4'b0100: e.idx = 2'd2;
         4'b1000: e.idx = 2'd3;
         default: e.idx = 2'd0;
      endcase
      return e;
   endfunction

   task automatic check(input string tag);
      exp_t e;
      exp_t o;
      o = {gnt, gnt_idx, gnt_vld, preempt};
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed gnt=%b", tag, gnt);
      end else begin
         e = sb.pop_front();
         assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b idx=%0d vld=%b pre=%b, expected gnt=%b idx=%0d vld=%b pre=%b",
                   tag, o.g, o.idx, o.vld, o.pre, e.g, e.idx, e.vld, e.pre);
         end
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] g, input logic p, input string tag);
      req = r;
      sb.push_back(mk(g, p));
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      req      = 4'b0000;

      #3;
      sb.push_back(mk(4'b0000, 1'b0));
      check("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single request and release to idle
      step(4'b0100, 4'b0100, 1'b0, "single_gnt");
      step(4'b0000, 4'b0000, 1'b0, "single_rel");
      step(4'b0000, 4'b0000, 1'b0, "idle_stays");

      // restart from ptr=0 for the rotation order
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;

      // fair rotation, each owner releases after two cycles
      step(4'b1111, 4'b0001, 1'b0, "rot0_a");
      step(4'b1111, 4'b0001, 1'b0, "rot0_b");
      step(4'b1110, 4'b0010, 1'b0, "rot1_a");
      step(4'b1111, 4'b0010, 1'b0, "rot1_b");
      step(4'b1101, 4'b0100, 1'b0, "rot2_a");
      step(4'b1111, 4'b0100, 1'b0, "rot2_b");
      step(4'b1011, 4'b1000, 1'b0, "rot3_a");
      step(4'b1111, 4'b1000, 1'b0, "rot3_b");
      step(4'b0111, 4'b0001, 1'b0, "rot0_again");
      step(4'b0000, 4'b0000, 1'b0, "rot_idle");

      // timeout: owner 0 holds 4 cycles, then 2, then back to 0
      step(4'b0001, 4'b0001, 1'b0, "to_c0");
      step(4'b0101, 4'b0001, 1'b0, "to_c1");
      step(4'b0101, 4'b0001, 1'b0, "to_c2");
      step(4'b0101, 4'b0001, 1'b0, "to_c3");
      step(4'b0101, 4'b0100, 1'b1, "to_rotate");
      step(4'b0101, 4'b0100, 1'b0, "to_pulse_end");
      step(4'b0101, 4'b0100, 1'b0, "to_2_c2");
      step(4'b0101, 4'b0100, 1'b0, "to_2_c3");
      step(4'b0101, 4'b0001, 1'b1, "to_back0");
      step(4'b0000, 4'b0000, 1'b0, "to_idle");

      // release coinciding with timeout is a plain hand-off
      step(4'b0001, 4'b0001, 1'b0, "rt_c0");
      step(4'b0101, 4'b0001, 1'b0, "rt_c1");
      step(4'b0101, 4'b0001, 1'b0, "rt_c2");
      step(4'b0101, 4'b0001, 1'b0, "rt_c3");
      step(4'b0100, 4'b0100, 1'b0, "rt_handoff");
      step(4'b0000, 4'b0000, 1'b0, "rt_idle");

      // sole owner never times out
      for (int i = 0; i < 20; i++) step(4'b0010, 4'b0010, 1'b0, "sole");
      step(4'b0000, 4'b0000, 1'b0, "sole_idle");

      // pointer wrap 3 -> 0 -> 3
      step(4'b1000, 4'b1000, 1'b0, "wrap_3");
      step(4'b1001, 4'b1000, 1'b0, "wrap_hold3");
      step(4'b0001, 4'b0001, 1'b0, "wrap_to0");
      step(4'b1001, 4'b0001, 1'b0, "wrap_hold0");
      step(4'b1000, 4'b1000, 1'b0, "wrap_back3");
      step(4'b1111, 4'b1000, 1'b0, "wrap_hold3b");

      // asynchronous reset while agent 3 owns the grant
      #1;
      rst_n = 1'b0;
      #1;
      sb.push_back(mk(4'b0000, 1'b0));
      check("async_rst");
      #3;
      rst_n = 1'b1;
      step(4'b1111, 4'b0001, 1'b0, "post_rst_gnt0");
      step(4'b0000, 4'b0000, 1'b0, "final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/arb4x2_rr.md
# arb4x2_rr

Four-requester round-robin arbiter that owns the shared 4-to-2 encode path. It converts up to four simultaneous request lines into a registered one-hot grant plus its 2-bit encoded index, which drive the encoder's select and output side. It sits between the requesting agents and the shared resource, enforcing fairness and a bounded hold time.

## Interface
- HOLD_MAX, 8, maximum consecutive cycles one owner keeps the grant while another requester waits; legal range 2..255
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  request lines, req[i] high = agent i wants the resource; level-held until done
- gnt  out  4  registered one-hot grant, all-zero when idle
- gnt_idx  out  2  encoded index of the granted agent, valid only with gnt_vld
- gnt_vld  out  1  high while any grant is active
- preempt  out  1  one-cycle pulse in the cycle a new owner's grant is first driven after a forced rotation

## Operation
- Reset values: gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, preempt=0, rotation pointer ptr=0, hold counter cnt=0, state IDLE.
- States: IDLE (no owner) and OWN (one owner, index cur).
- Pick rule: first i with req[i]=1, scanning circularly from ptr (ptr, ptr+1, ... mod 4). The scan may be masked to exclude cur.
- IDLE: if req!=0, go to OWN with cur=pick(unmasked), ptr<=cur+1 (mod 4, wraps 3->0), cnt<=0. Otherwise stay in IDLE.
- OWN, release: if req[cur]=0 and another request is pending, hand off directly to pick(masked) with no idle cycle, and set cnt<=0. If no other request is pending, go to IDLE and clear gnt.
- OWN, timeout: if req[cur]=1, cnt==HOLD_MAX-1 and another request is pending, rotate to pick(masked), set cnt<=0, ptr<=new+1, and pulse preempt.
- OWN, hold: otherwise stay on cur. cnt increments and saturates at HOLD_MAX-1. With no competitor, the owner keeps the grant indefinitely.
- Outputs: gnt, gnt_idx and gnt_vld are registered copies of the state; gnt_idx equals the binary encoding of gnt.
- Simultaneous release and timeout: handled as a release, so preempt=0.
- A req[i] for i!=cur never disturbs the current grant before release or timeout.
- Asynchronous reset mid-grant: all outputs clear immediately; arbitration restarts from ptr=0.

## Timing
- Request to grant latency: 1 cycle. A req sampled at edge n drives gnt from edge n.
- Release to next grant: 1 cycle. A deassertion sampled at edge n moves gnt to the new owner at edge n; there is never a cycle with two grants.
- Back-to-back requests by the same agent after release are served in rotation order, not immediately.
- Worst-case wait for any requester: 3*HOLD_MAX cycles plus 1.
- cnt width is $clog2(HOLD_MAX).
- preempt is high for exactly one cycle, aligned with the first cycle of the new grant.

## Structure
- Shared package arb4x2_pkg holds:
  - state encoding constants IDLE=1'b0, OWN=1'b1
  - N_REQ=4 and IDX_W=2
  - an onehot-to-index function reused by the encoder path
- One combinational sub-module, arb4x2_pick: inputs req[3:0], ptr[1:0], mask[3:0]; outputs idx[1:0] and found. It is instantiated once and used for both masked and unmasked picks by driving the mask.
- All other logic (FSM, ptr, cnt, output registers) lives in the top module.

## Test plan
- Reset and single request: release rst_n, drive req=0100 -> gnt=0100 and gnt_idx=2 one cycle later; drop req -> gnt=0000 and gnt_vld=0 next cycle.
- Fair rotation: hold req=1111 with each owner releasing after 2 cycles -> grant order 0,1,2,3,0 and no idle cycle between owners.
- Timeout: HOLD_MAX=4, req0 held high, req2 raised at cycle 1 -> grant moves 0->2 at the 4th grant cycle with preempt=1 for one cycle.
- Sole owner: HOLD_MAX=4, only req1 held for 20 cycles -> gnt=0010 throughout, preempt never asserted.
- Pointer wrap: owner 3 releases while req=1001 -> next grant is agent 0, then agent 3 after agent 0 releases.
- Reset mid-grant: assert rst_n=0 while gnt=1000 -> outputs clear without waiting for clk; after release with req=1111 -> first grant is agent 0.
